// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared state encoding, default widths and helpers for the
//               RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int C_NUM_REQ_DEF    = 4;
    localparam int C_ADDR_WIDTH_DEF = 2;
    localparam int C_DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Width of a requester index / round-robin pointer (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. Returns the first asserted
//               request at or after the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ_DEF,
    parameter int IDX_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic found_d;
    int   cand_d;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        win_o   = '0;
        idx_o   = '0;
        found_d = 1'b0;
        cand_d  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_d = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_d && req_i[cand_d]) begin
                found_d       = 1'b1;
                win_o[cand_d] = 1'b1;
                idx_o         = IDX_W'(cand_d);
            end
        end
        any_o = found_d;
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter sharing one synchronous-read RAM port
//               among NUM_REQ requesters with a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = C_NUM_REQ_DEF,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = C_DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               ack,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic                             ram_we,
    output logic [ADDR_WIDTH-1:0]            ram_address,
    output logic [DATA_WIDTH-1:0]            ram_data_in,
    input  logic [DATA_WIDTH-1:0]            ram_data_out
);

    localparam int IDX_W = ptr_width(NUM_REQ);

    state_e                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   cmd_we_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   busy_q;
    logic                   ram_we_q;
    logic [ADDR_WIDTH-1:0]  ram_address_q;
    logic [DATA_WIDTH-1:0]  ram_data_in_q;

    logic [NUM_REQ-1:0]     win_d;
    logic [IDX_W-1:0]       win_idx_d;
    logic                   any_d;
    logic [IDX_W-1:0]       ptr_d;
    logic                   sel_we_d;
    logic [ADDR_WIDTH-1:0]  sel_addr_d;
    logic [DATA_WIDTH-1:0]  sel_wdata_d;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .win_o   (win_d),
        .idx_o   (win_idx_d),
        .any_o   (any_d)
    );

    // Pointer moves just past the winner; command fields of the winner.
    always_comb begin
        ptr_d       = (int'(win_idx_d) == NUM_REQ - 1) ? '0 : win_idx_d + 1'b1;
        sel_we_d    = req_we[win_idx_d];
        sel_addr_d  = req_addr[int'(win_idx_d)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_d = req_wdata[int'(win_idx_d)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Transaction FSM; the RAM command is loaded on grant so it is on the
    // port throughout ISSUE, and reset drops every output at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cmd_we_q      <= 1'b0;
            gnt_q         <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        gnt_q         <= win_d;
                        ptr_q         <= ptr_d;
                        cmd_we_q      <= sel_we_d;
                        ram_we_q      <= sel_we_d;
                        ram_address_q <= sel_addr_d;
                        ram_data_in_q <= sel_wdata_d;
                        busy_q        <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we_q <= 1'b0;
                    if (cmd_we_q) begin
                        ack_q   <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata_q <= ram_data_out;
                    ack_q   <= gnt_q;
                    state_q <= RESP;
                end
                RESP: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign ram_we      = ram_we_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;

endmodule
`default_nettype wire
